shift_add_mul_ctrl: RTL and testbench

Multi-cycle unsigned multiplier controller for the KGP-RISC ALU. It sequences a shared W-bit carry-lookahead adder through W shift-and-add iterations to form a 2W-bit product. It sits beside the single-cycle ALU path, and the execute stage stalls on it through a start/ready/done handshake.

---
 rtl/shift_add_mul_ctrl_pkg.sv | 15 +
 rtl/shift_add_mul_ctrl_cla.sv | 51 +++++
 rtl/shift_add_mul_ctrl.sv | 98 +++++++++
 tb/tb_shift_add_mul_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mul_ctrl_pkg.sv
// Shared ALU definitions for the multi-cycle shift-and-add multiplier.
package shift_add_mul_ctrl_pkg;

  // Default operand width of the multiplier.
  localparam int MUL_W = 32;

  // Controller states; the unused code is decoded and steers back to idle.
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2,
    MUL_ILL  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/shift_add_mul_ctrl_cla.sv
// W-bit carry-lookahead adder built from 4-bit CLA slices. Each slice
// resolves its internal carries in parallel and exports group
// generate/propagate; the group lookahead unit turns those into slice
// carry-ins.
module cla_adder_w #(
  parameter int W = 32  // multiple of 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NS = W / 4;

  logic [NS:0]   gc;   // slice carry-ins, gc[NS] is the adder carry-out
  logic [NS-1:0] gg;   // slice group generate
  logic [NS-1:0] gp;   // slice group propagate

  assign gc[0] = cin;
  assign cout  = gc[NS];

  genvar s;
  generate
    for (s = 0; s < NS; s++) begin : g_slice
      logic [3:0] p, g, c;

      // Bit-level propagate/generate for this slice.
      assign p = a[4*s +: 4] ^ b[4*s +: 4];
      assign g = a[4*s +: 4] & b[4*s +: 4];

      // Internal carries, all in terms of the slice carry-in.
      assign c[0] = gc[s];
      assign c[1] = g[0] | (p[0] & gc[s]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & gc[s]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & gc[s]);

      assign gg[s] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
      assign gp[s] = &p;

      assign sum[4*s +: 4] = p ^ c;

      // Group lookahead: slice carry-out from group G/P and carry-in.
      assign gc[s+1] = gg[s] | (gp[s] & gc[s]);
    end
  endgenerate

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Multi-cycle unsigned shift-and-add multiplier controller. One shared
// W-bit CLA add per cycle over W iterations forms the 2W-bit product;
// start/ready/done handshake toward the execute stage.
module shift_add_mul_ctrl
  import shift_add_mul_ctrl_pkg::*;
#(
  parameter int W = MUL_W  // multiple of 4, >= 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic           hi_nz
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  mul_state_t     state;
  logic [W-1:0]   mcand;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   add_b;
  logic [W-1:0]   add_s;
  logic           add_c;
  logic [2*W-1:0] acc_nxt;

  // Adder always sits in the path; the addend is zeroed when the
  // multiplier bit is clear so the delay does not depend on data.
  assign add_b = acc[0] ? mcand : '0;

  cla_adder_w #(.W(W)) u_add (
    .a    (acc[2*W-1:W]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_c)
  );

  // Carry becomes the new MSB as the whole accumulator shifts right.
  assign acc_nxt = {add_c, add_s, acc[W-1:1]};

  // Controller FSM with registered handshake outputs, counter and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MUL_IDLE;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      hi_nz   <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE, MUL_DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            acc   <= {{W{1'b0}}, b};
            cnt   <= '0;
            state <= MUL_RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= MUL_IDLE;
          end
        end
        MUL_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= acc_nxt;
            hi_nz   <= |acc_nxt[2*W-1:W];
            state   <= MUL_DONE;
            busy    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= MUL_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Self-checking bench for shift_add_mul_ctrl: cycle-level behavioural model
// (accept/countdown/multiply) compared on every negedge, plus directed cases
// with literal expectations.
module tb_shift_add_mul_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ready, busy, done, hi_nz;
  logic [63:0]   product;

  int total = 0;
  int bad   = 0;

  shift_add_mul_ctrl #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product),
    .hi_nz   (hi_nz)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op finishes W cycles later with a*b.
  int          m_rem  = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_prod = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_prod = '0;
    end else if (!m_busy && start) begin
      m_pend = 64'(a) * 64'(b);
      m_rem  = W; m_busy = 1'b1; m_done = 1'b0;
    end else if (m_busy) begin
      m_rem--;
      m_done = (m_rem == 0);
      if (m_rem == 0) begin
        m_busy = 1'b0;
        m_prod = m_pend;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("ready",   64'(ready), 64'(!m_busy));
      check("busy",    64'(busy),  64'(m_busy));
      check("done",    64'(done),  64'(m_done));
      check("product", product,    m_prod);
      check("hi_nz",   64'(hi_nz), 64'(|m_prod[63:32]));
      check("excl",    64'(busy & done), 64'd0);
      check("rdy_nb",  64'(ready), 64'(!busy));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 60) begin @(negedge clk); n++; end
    check("wait_ready_timeout", 64'(ready), 64'd1);
  endtask

  // One op, start held a single cycle; returns cycles until done is seen.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, output int lat);
    wait_ready();
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
  endtask

  initial begin
    int lat, n;
    logic [63:0] lit;

    // Reset state.
    @(negedge clk); @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_prod",  product,    64'd0);
    check("rst_hinz",  64'(hi_nz), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Small operands.
    run_op(32'd3, 32'd5, lat);
    check("lat_3x5",  64'(lat), 64'd33);
    check("prod_3x5", product,  64'h0000_0000_0000_000F);
    check("hinz_3x5", 64'(hi_nz), 64'd0);
    check("model_3x5", m_prod,  64'h0000_0000_0000_000F);

    // Carry-out captured every iteration.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("prod_max", product,    64'hFFFF_FFFE_0000_0001);
    check("hinz_max", 64'(hi_nz), 64'd1);
    check("model_max", m_prod,    64'hFFFF_FFFE_0000_0001);

    // Zero operands, same latency.
    run_op(32'h1234_5678, 32'd0, lat);
    check("lat_bz",  64'(lat), 64'd33);
    check("prod_bz", product,  64'd0);
    run_op(32'd0, 32'h8000_0000, lat);
    check("lat_az",  64'(lat), 64'd33);
    check("prod_az", product,  64'd0);
    check("hinz_az", 64'(hi_nz), 64'd0);

    // Start held; operands change mid-run and become the second op.
    wait_ready();
    a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 10) begin a = 32'd11; b = 32'd13; end
      @(negedge clk); lat++;
    end
    check("lat_held1",  64'(lat), 64'd33);
    check("prod_held1", product,  64'd42);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("gap_held2",  64'(n),  64'd33);
    check("prod_held2", product, 64'd143);

    // Reset in the middle of a run aborts it.
    wait_ready();
    a = 32'd100; b = 32'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_busy",  64'(busy),  64'd0);
    check("abort_prod",  product,    64'd0);
    n = 0;
    repeat (40) begin @(negedge clk); if (done) n++; end
    check("abort_nodone", 64'(n), 64'd0);
    run_op(32'd7, 32'd9, lat);
    check("lat_7x9",  64'(lat), 64'd33);
    check("prod_7x9", product,  64'd63);

    // Reset wins over a simultaneous start.
    wait_ready();
    rst = 1'b1; start = 1'b1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    check("rst_start_prod", product,   64'd0);

    // Randomized traffic, including starts while busy and corner operands.
    for (int i = 0; i < 30000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: a = '0;
        1: a = '1;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        default: b = $urandom;
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
